result_drain: RTL and testbench

- Host-side sequencer for the processor's result path.
- Pulses the processor start, waits for processor completion, then reads result memory addresses 0..DEPTH-1 in order through the result-memory read port.
- Emits each word on a valid/ready stream with a last flag.
- Is the hardware reader counterpart of the host load/start/readback protocol, so software no longer walks the result memory word by word.

---
 rtl/result_drain_pkg.sv | 22 ++
 rtl/result_drain_skid_fifo.sv | 57 +++++
 rtl/result_drain.sv | 158 +++++++++++++++
 tb/tb_result_drain.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_drain_pkg.sv
// Shared definitions for the result drain sequencer: state encoding,
// skid FIFO sizing and the default result-path widths.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 10
`endif

package result_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } drain_state_t;

  localparam int unsigned DRAIN_FIFO_DEPTH = 2;
  localparam int unsigned DRAIN_FIFO_CNT_W = $clog2(DRAIN_FIFO_DEPTH + 1);

endpackage

// File: rtl/result_drain_skid_fifo.sv
// drain_skid_fifo: 2-entry FIFO with a registered head word.
// The head register always holds the oldest entry so the stream output is
// a direct register with no read mux.
module drain_skid_fifo
  import result_drain_pkg::*;
#(
  parameter int unsigned WIDTH = 33
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_push,
  input  logic [WIDTH-1:0]            i_din,
  input  logic                        i_pop,
  output logic [WIDTH-1:0]            o_head,
  output logic                        o_valid,
  output logic [DRAIN_FIFO_CNT_W-1:0] o_count
);

  logic [WIDTH-1:0]            r_head;
  logic [WIDTH-1:0]            r_tail;
  logic [DRAIN_FIFO_CNT_W-1:0] r_count;

  // Head/tail shift register; push and pop together keep the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_count == '0) r_head <= i_din;
          else               r_tail <= i_din;
          r_count <= r_count + 1'b1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 1'b1;
        end
        2'b11: begin
          if (r_count == DRAIN_FIFO_CNT_W'(1)) begin
            r_head <= i_din;
          end else begin
            r_head <= r_tail;
            r_tail <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head  = r_head;
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/result_drain.sv
// result_drain: pulses processor start, waits for done, then streams result
// memory words 0..DEPTH-1 out on a valid/ready interface with a last flag.
// Optional: define DRAIN_CHECKSUM_EN to add checksum_o (sum of accepted words).
module result_drain
  import result_drain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start_i,
  output logic                  proc_start_o,
  input  logic                  proc_done_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_ena_o,
  output logic                  mem_wea_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o,
  output logic                  busy_o,
  output logic                  done_o
`ifdef DRAIN_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum_o
`endif
);

  localparam logic [ADDR_WIDTH:0]       LP_DEPTH      = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]       LP_LAST       = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [DRAIN_FIFO_CNT_W:0] LP_FIFO_DEPTH = (DRAIN_FIFO_CNT_W + 1)'(DRAIN_FIFO_DEPTH);

  drain_state_t                r_state;
  logic                        r_proc_start;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_inflight;
  logic                        r_inflight_last;
  logic [ADDR_WIDTH:0]         r_rd_addr;

  logic                        w_issue;
  logic                        w_pop;
  logic                        w_start_run;
  logic                        w_fifo_valid;
  logic                        w_head_last;
  logic [DATA_WIDTH-1:0]       w_head_data;
  logic [DATA_WIDTH:0]         w_fifo_din;
  logic [DATA_WIDTH:0]         w_fifo_head;
  logic [DRAIN_FIFO_CNT_W-1:0] w_fifo_count;
  logic [DRAIN_FIFO_CNT_W:0]   w_occupancy;

  assign w_start_run = (r_state == ST_IDLE) && start_i;
  assign w_pop       = w_fifo_valid && m_ready_i;
  assign w_fifo_din  = {r_inflight_last, mem_data_i};
  assign {w_head_last, w_head_data} = w_fifo_head;

  // Issue a read only while queued plus in-flight words (less the one
  // leaving this cycle) still fit the skid FIFO.
  always_comb begin
    w_occupancy = {1'b0, w_fifo_count} + {{DRAIN_FIFO_CNT_W{1'b0}}, r_inflight};
    w_issue     = 1'b0;
    if ((r_state == ST_DRAIN) && (r_rd_addr < LP_DEPTH)) begin
      w_issue = w_occupancy < (LP_FIFO_DEPTH + {{DRAIN_FIFO_CNT_W{1'b0}}, w_pop});
    end
  end

  // Sequencer FSM with registered start/busy/done outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= ST_IDLE;
      r_proc_start <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_state      <= ST_RUN;
            r_proc_start <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        ST_RUN: begin
          if (proc_done_i) begin
            r_state      <= ST_DRAIN;
            r_proc_start <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (w_pop && w_head_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Read address counter and one-cycle read-latency tracking.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rd_addr       <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_rd_addr == LP_LAST);
      if (w_start_run)  r_rd_addr <= '0;
      else if (w_issue) r_rd_addr <= r_rd_addr + 1'b1;
    end
  end

  drain_skid_fifo #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_push  (r_inflight),
    .i_din   (w_fifo_din),
    .i_pop   (w_pop),
    .o_head  (w_fifo_head),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

`ifdef DRAIN_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_checksum;

  // Running sum of accepted words, cleared when a run starts.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)         r_checksum <= '0;
    else if (w_start_run) r_checksum <= '0;
    else if (w_pop)   r_checksum <= r_checksum + w_head_data;
  end

  assign checksum_o = r_checksum;
`endif

  assign proc_start_o = r_proc_start;
  assign mem_ena_o    = w_issue;
  assign mem_addr_o   = r_rd_addr[ADDR_WIDTH-1:0];
  assign mem_wea_o    = 1'b0;
  assign m_data_o     = w_head_data;
  assign m_valid_o    = w_fifo_valid;
  assign m_last_o     = w_fifo_valid && w_head_last;
  assign busy_o       = r_busy;
  assign done_o       = r_done;

endmodule

// File: tb/tb_result_drain.sv
// Testbench for result_drain: scoreboard of expected words per run, a
// monitor that checks every accepted word and stream invariants, and a
// directed sequence of runs (full ready, random ready, long processor
// wait, start during drain, reset mid-drain, random memory contents).
module tb_result_drain;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          start_i = 1'b0;
  logic          proc_done_i = 1'b0;
  logic          m_ready_i = 1'b1;
  logic          proc_start_o, mem_ena_o, mem_wea_o;
  logic          m_valid_o, m_last_o, busy_o, done_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_i = '0;
  logic [DW-1:0] m_data_o;
`ifdef DRAIN_CHECKSUM_EN
  logic [DW-1:0] checksum_o;
`endif

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] mem [DEPTH];
  exp_t          exp_q[$];
  int            exp_addr = 0;
  int            outstanding = 0;
  int            done_cnt = 0;
  int            last_cnt = 0;
  int            acc_cnt = 0;
  logic [DW-1:0] exp_sum = '0;
  bit            rand_ready = 1'b0;
  logic          prev_v = 1'b0;
  logic          prev_r = 1'b0;
  logic [DW-1:0] prev_d = '0;

  result_drain #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .start_i      (start_i),
    .proc_start_o (proc_start_o),
    .proc_done_i  (proc_done_i),
    .mem_addr_o   (mem_addr_o),
    .mem_ena_o    (mem_ena_o),
    .mem_wea_o    (mem_wea_o),
    .mem_data_i   (mem_data_i),
    .m_data_o     (m_data_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_last_o     (m_last_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
`ifdef DRAIN_CHECKSUM_EN
    ,
    .checksum_o   (checksum_o)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Result of op k of the standard program with A=1, B=2.
  function automatic logic [DW-1:0] op_result(input int k);
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    a = 1;
    b = 2;
    case (k)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a << b;
      5: return a >> b;
      6: return (a < b) ? 1 : 0;
      default: return a ^ b;
    endcase
  endfunction

  // Synchronous result memory: data valid the cycle after enable.
  always @(posedge CLK) begin
    if (mem_ena_o) mem_data_i <= mem[mem_addr_o];
  end

  // Ready driver, changes just after the active edge.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      m_ready_i = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  // Monitor: read ordering, accepted words vs scoreboard, stream invariants.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      prev_v      = 1'b0;
      prev_r      = 1'b0;
      outstanding = 0;
    end else begin
      chk("wea_zero", mem_wea_o, 0);
      if (mem_ena_o) begin
        chk("rd_in_range", exp_addr < DEPTH, 1);
        chk("rd_addr", mem_addr_o, exp_addr[AW-1:0]);
        exp_addr++;
      end
      if (prev_v && !prev_r) begin
        chk("hold_valid", m_valid_o, 1);
        chk("hold_data", m_data_o, prev_d);
      end
      if (m_last_o) begin
        last_cnt++;
        chk("last_has_valid", m_valid_o, 1);
      end
      if (m_valid_o && m_ready_i) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL extra_word: got %0h, expected no word", m_data_o);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", m_data_o, e.d);
          chk("word_last", m_last_o, e.l);
        end
        acc_cnt++;
      end
      outstanding = outstanding + int'(mem_ena_o) - int'(m_valid_o && m_ready_i);
      chk("outstanding_le2", outstanding <= 2, 1);
      if (done_o) done_cnt++;
      prev_v = m_valid_o;
      prev_r = m_ready_i;
      prev_d = m_data_o;
    end
  end

  task automatic do_run(input bit rnd_mem, input bit rnd_ready, input int hold,
                        input bit poke_start, input int abort_after);
    int k;
    rand_ready = rnd_ready;
    exp_q.delete();
    exp_sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = rnd_mem ? $urandom : op_result(i / 128);
      exp_q.push_back('{d: mem[i], l: (i == DEPTH - 1)});
      exp_sum += mem[i];
    end
    exp_addr = 0;
    done_cnt = 0;
    last_cnt = 0;
    acc_cnt  = 0;

    @(negedge CLK);
    start_i = 1'b1;
    @(negedge CLK);
    start_i = 1'b0;
    chk("run_proc_start", proc_start_o, 1);
    chk("run_busy", busy_o, 1);
    chk("run_no_read", mem_ena_o, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      chk("wait_proc_start", proc_start_o, 1);
      chk("wait_no_read", mem_ena_o, 0);
      chk("wait_busy", busy_o, 1);
    end
    proc_done_i = 1'b1;
    @(negedge CLK);
    proc_done_i = 1'b0;
    chk("drain_first_ena", mem_ena_o, 1);
    chk("drain_first_addr", mem_addr_o, 0);
    chk("drain_start_low", proc_start_o, 0);
    chk("drain_c0_valid", m_valid_o, 0);
    @(negedge CLK);
    chk("drain_c1_valid", m_valid_o, 0);
    @(negedge CLK);
    chk("drain_c2_valid", m_valid_o, 1);

    if (poke_start) begin
      repeat (20) @(negedge CLK);
      start_i = 1'b1;
      @(negedge CLK);
      start_i = 1'b0;
    end

    if (abort_after > 0) begin
      for (k = 0; k < 20000; k++) begin
        @(negedge CLK);
        if (acc_cnt >= abort_after) break;
      end
      chk("abort_reached", acc_cnt >= abort_after, 1);
      #2;
      RST = 1'b0;
      #1;
      chk("rst_proc_start", proc_start_o, 0);
      chk("rst_mem_ena", mem_ena_o, 0);
      chk("rst_mem_addr", mem_addr_o, 0);
      chk("rst_m_valid", m_valid_o, 0);
      chk("rst_m_data", m_data_o, 0);
      chk("rst_m_last", m_last_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      exp_q.delete();
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      return;
    end

    for (k = 0; k < 20000; k++) begin
      @(negedge CLK);
      if (done_o) break;
    end
    chk("done_seen", done_o, 1);
    chk("done_busy", busy_o, 1);
    chk("queue_empty", exp_q.size(), 0);
    chk("words_accepted", acc_cnt, DEPTH);
    chk("last_count", last_cnt, 1);
`ifdef DRAIN_CHECKSUM_EN
    chk("checksum", checksum_o, exp_sum);
`endif
    @(negedge CLK);
    chk("done_pulse_end", done_o, 0);
    chk("idle_busy", busy_o, 0);
    chk("done_count", done_cnt, 1);
    repeat (8) @(negedge CLK);
    chk("stay_idle", busy_o, 0);
    chk("stay_no_start", proc_start_o, 0);
`ifdef DRAIN_CHECKSUM_EN
    chk("checksum_held", checksum_o, exp_sum);
`endif
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    chk("reset_proc_start", proc_start_o, 0);
    chk("reset_mem_ena", mem_ena_o, 0);
    chk("reset_m_valid", m_valid_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_m_last", m_last_o, 0);
    RST = 1'b1;
    @(negedge CLK);

    do_run(1'b0, 1'b0, 3,   1'b0, 0);
    do_run(1'b0, 1'b1, 5,   1'b0, 0);
    do_run(1'b0, 1'b0, 500, 1'b0, 0);
    do_run(1'b0, 1'b1, 2,   1'b1, 0);
    do_run(1'b0, 1'b1, 2,   1'b0, 300);
    do_run(1'b0, 1'b0, 2,   1'b0, 0);
    do_run(1'b1, 1'b1, 4,   1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
